anita3_trigger_arbiter: RTL and testbench

- Sits between the four trigger sources and the buffer manager, all on clk250_i.
  - Sources: bit0 RF, bit1 PPS1, bit2 PPS2, bit3 soft.
- Latches each source's request, applies the source enables and an RF prescaler, and grants one source at a time by fixed priority.
- Issues a single-cycle trigger plus a one-hot source tag to the buffer manager, honouring its dead flag and a minimum holdoff between issued triggers.
- Counts requests lost to collisions.

---
 rtl/anita3_trigger_arbiter.sv | 134 +++++++++++++
 tb/tb_anita3_trigger_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/anita3_trigger_arbiter.sv
// Trigger arbiter: latches RF/PPS1/PPS2/soft requests, prescales RF, and issues
// one fixed-priority trigger at a time to the buffer manager with a holdoff.
module anita3_trigger_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned HOLDOFF    = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk250_i,
  input  logic                  rst_i,
  input  logic [NUM_SRC-1:0]    trig_i,
  input  logic [NUM_SRC-1:0]    src_en_i,
  input  logic [PRESCALE_W-1:0] rf_prescale_i,
  input  logic                  dead_i,
  output logic                  trig_o,
  output logic [NUM_SRC-1:0]    trig_src_o,
  output logic [NUM_SRC-1:0]    pending_o,
  output logic [15:0]           drop_count_o,
  output logic                  busy_o
);

  localparam int unsigned HO_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLDOFF
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [HO_W-1:0]         hcnt_q, hcnt_d;
  logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
  logic [NUM_SRC-1:0]      pend_q, pend_d;
  logic [15:0]             drop_q, drop_d;

  logic                    rf_hit, rf_pass;
  logic [NUM_SRC-1:0]      req, clr, keep, drop, sel;
  logic                    found;
  logic [16:0]             drop_sum;

  // RF prescaler: >= compare keeps it moving if the ratio is lowered mid-count
  always_comb begin
    rf_hit  = trig_i[0] & src_en_i[0];
    rf_pass = rf_hit & (pcnt_q >= rf_prescale_i);
    pcnt_d  = pcnt_q;
    if (rf_hit) begin
      pcnt_d = rf_pass ? '0 : pcnt_q + PRESCALE_W'(1);
    end
  end

  // Pending latch and collision detection; a grant-clear coinciding with a new
  // arrival leaves the bit set without counting a drop.
  always_comb begin
    req    = trig_i & src_en_i;
    req[0] = rf_pass;
    clr    = ~src_en_i | ((state_q == ST_ISSUE) ? grant_q : '0);
    keep   = pend_q & ~clr;
    drop   = req & keep;
    pend_d = req | keep;

    drop_sum = {1'b0, drop_q};
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      drop_sum = drop_sum + 17'(drop[i]);
    end
    drop_d = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pend_q[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!dead_i && (pend_q != '0)) begin
          grant_d = sel;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        hcnt_d = HO_LOAD;
        // with HOLDOFF == 2 the ISSUE and IDLE cycles alone make the spacing
        if (HO_LOAD == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        hcnt_d = hcnt_q - HO_W'(1);
        if (hcnt_q == HO_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign trig_o       = (state_q == ST_ISSUE);
  assign trig_src_o   = (state_q == ST_ISSUE) ? grant_q : '0;
  assign busy_o       = (state_q != ST_IDLE);
  assign pending_o    = pend_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_anita3_trigger_arbiter.sv
// Directed bench for anita3_trigger_arbiter: per-cycle vector table plus
// hand-written sequences for priority, prescale, dead, saturation and reset.
module tb_anita3_trigger_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  trig, en;
  logic [7:0]  presc;
  logic        dead;
  logic        trig_o, busy_o;
  logic [3:0]  trig_src_o, pending_o;
  logic [15:0] drop_count_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned leak = 0;
  int unsigned ev_cyc[$];
  logic [3:0]  ev_src[$];

  typedef struct {
    logic [3:0]  trig;
    logic [3:0]  en;
    logic [3:0]  x_pend;
    logic        x_trig;
    logic [3:0]  x_src;
    logic        x_busy;
    logic [15:0] x_drop;
  } vec_t;
  vec_t tbl[$];

  anita3_trigger_arbiter #(.NUM_SRC(4), .HOLDOFF(16), .PRESCALE_W(8)) dut (
    .clk250_i      (clk),
    .rst_i         (rst),
    .trig_i        (trig),
    .src_en_i      (en),
    .rf_prescale_i (presc),
    .dead_i        (dead),
    .trig_o        (trig_o),
    .trig_src_o    (trig_src_o),
    .pending_o     (pending_o),
    .drop_count_o  (drop_count_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (trig_o) begin
        ev_cyc.push_back(cyc);
        ev_src.push_back(trig_src_o);
      end else if (trig_src_o != 4'b0000) begin
        leak <= leak + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] v, output int unsigned e);
    @(negedge clk);
    trig = v;
    e = cyc + 1;
    @(negedge clk);
    trig = 4'b0000;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void add(input logic [3:0] t, input logic [3:0] e, input logic [3:0] p,
                              input logic tr, input logic [3:0] s, input logic b,
                              input logic [15:0] d);
    tbl.push_back('{t, e, p, tr, s, b, d});
  endfunction

  initial begin
    int unsigned e;
    int unsigned exp_ev[$];
    logic [15:0] exp_drop;

    rst = 1'b1; trig = '0; en = 4'b1111; presc = 8'd0; dead = 1'b0;
    idle(3);
    chk("rst.trig", trig_o, 0);
    chk("rst.src", trig_src_o, 0);
    chk("rst.pend", pending_o, 0);
    chk("rst.drop", drop_count_o, 0);
    chk("rst.busy", busy_o, 0);
    rst = 1'b0;
    idle(2);

    // single RF, collisions, enable clear, holdoff spacing, grant-clear vs arrival
    add(4'b0001, 4'b1111, 4'b0001, 0, 4'b0000, 0, 0);
    add(4'b0000, 4'b1111, 4'b0001, 1, 4'b0001, 1, 0);
    add(4'b0000, 4'b1111, 4'b0000, 0, 4'b0000, 1, 0);
    add(4'b0100, 4'b1111, 4'b0100, 0, 4'b0000, 1, 0);
    add(4'b0100, 4'b1111, 4'b0100, 0, 4'b0000, 1, 1);
    add(4'b0110, 4'b1111, 4'b0110, 0, 4'b0000, 1, 2);
    add(4'b0000, 4'b1101, 4'b0100, 0, 4'b0000, 1, 2);
    for (int i = 0; i < 9; i++) add(4'b0000, 4'b1111, 4'b0100, 0, 4'b0000, 1, 2);
    add(4'b0000, 4'b1111, 4'b0100, 0, 4'b0000, 0, 2);
    add(4'b0000, 4'b1111, 4'b0100, 1, 4'b0100, 1, 2);
    add(4'b0100, 4'b1111, 4'b0100, 0, 4'b0000, 1, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      trig = tbl[i].trig;
      en   = tbl[i].en;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.pend", i), pending_o, tbl[i].x_pend);
      chk($sformatf("vec%0d.trig", i), trig_o, tbl[i].x_trig);
      chk($sformatf("vec%0d.src", i), trig_src_o, tbl[i].x_src);
      chk($sformatf("vec%0d.busy", i), busy_o, tbl[i].x_busy);
      chk($sformatf("vec%0d.drop", i), drop_count_o, tbl[i].x_drop);
    end
    @(negedge clk);
    trig = '0; en = 4'b1111;
    exp_drop = 16'd2;
    idle(40);
    chk("drain.pend", pending_o, 0);
    chk("drain.busy", busy_o, 0);

    // PPS1 + soft together: priority and exact HOLDOFF spacing
    ev_cyc.delete(); ev_src.delete();
    pulse(4'b1010, e);
    idle(50);
    chk("prio.count", ev_cyc.size(), 2);
    if (ev_cyc.size() >= 2) begin
      chk("prio.lat", ev_cyc[0], e + 1);
      chk("prio.src0", ev_src[0], 4'b0010);
      chk("prio.space", ev_cyc[1] - ev_cyc[0], 16);
      chk("prio.src1", ev_src[1], 4'b1000);
    end
    chk("prio.drop", drop_count_o, exp_drop);

    // RF prescale 3: 4th, 8th, 12th pulses pass
    presc = 8'd3;
    ev_cyc.delete(); ev_src.delete();
    for (int k = 1; k <= 12; k++) begin
      pulse(4'b0001, e);
      if (k % 4 == 0) exp_ev.push_back(e + 1);
      idle(18);
    end
    idle(20);
    chk("presc.count", ev_cyc.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < ev_cyc.size()) begin
        chk($sformatf("presc.cyc%0d", k), ev_cyc[k], exp_ev[k]);
        chk($sformatf("presc.src%0d", k), ev_src[k], 4'b0001);
      end
    end
    chk("presc.drop", drop_count_o, exp_drop);
    presc = 8'd0;

    // dead held: soft pulses 5 cycles apart collide
    @(negedge clk);
    dead = 1'b1;
    ev_cyc.delete(); ev_src.delete();
    for (int k = 0; k < 3; k++) begin
      pulse(4'b1000, e);
      idle(3);
    end
    exp_drop = exp_drop + 16'd2;
    chk("dead.pend", pending_o, 4'b1000);
    chk("dead.drop", drop_count_o, exp_drop);
    chk("dead.none", ev_cyc.size(), 0);
    chk("dead.busy", busy_o, 0);
    @(negedge clk);
    dead = 1'b0;
    e = cyc + 1;
    idle(30);
    chk("dead.rel.count", ev_cyc.size(), 1);
    if (ev_cyc.size() >= 1) begin
      chk("dead.rel.src", ev_src[0], 4'b1000);
      chk("dead.rel.lat", (ev_cyc[0] - e) <= 1, 1);
    end

    // all four pending then all four collide in one cycle
    @(negedge clk);
    dead = 1'b1;
    ev_cyc.delete(); ev_src.delete();
    pulse(4'b1111, e);
    pulse(4'b1111, e);
    exp_drop = exp_drop + 16'd4;
    chk("multi.pend", pending_o, 4'b1111);
    chk("multi.drop", drop_count_o, exp_drop);
    @(negedge clk);
    dead = 1'b0;
    idle(80);
    chk("multi.count", ev_cyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ev_cyc.size()) begin
        chk($sformatf("multi.src%0d", k), ev_src[k], 4'b0001 << k);
        if (k > 0) chk($sformatf("multi.space%0d", k), ev_cyc[k] - ev_cyc[k-1], 16);
      end
    end

    // saturation via continuous colliding soft requests
    @(negedge clk);
    dead = 1'b1;
    trig = 4'b1000;
    idle(65537);
    trig = 4'b0000;
    idle(2);
    chk("sat.drop", drop_count_o, 16'hFFFF);
    pulse(4'b1000, e);
    idle(2);
    chk("sat.stick", drop_count_o, 16'hFFFF);
    ev_cyc.delete(); ev_src.delete();
    dead = 1'b0;
    idle(30);
    chk("sat.drain", ev_cyc.size(), 1);

    // asynchronous reset in HOLDOFF with PPS2 pending
    pulse(4'b0001, e);
    idle(4);
    pulse(4'b0100, e);
    idle(2);
    chk("ar.pre.busy", busy_o, 1);
    chk("ar.pre.pend", pending_o, 4'b0100);
    #1 rst = 1'b1;
    #1;
    chk("ar.trig", trig_o, 0);
    chk("ar.src", trig_src_o, 0);
    chk("ar.pend", pending_o, 0);
    chk("ar.drop", drop_count_o, 0);
    chk("ar.busy", busy_o, 0);
    idle(3);
    rst = 1'b0;
    ev_cyc.delete(); ev_src.delete();
    idle(40);
    chk("ar.quiet", ev_cyc.size(), 0);
    chk("ar.quiet.pend", pending_o, 0);

    chk("src_zero_when_idle", leak, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
